// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic result drain: default geometry,
// the row container type and the per-column deskew delay helper.
package systolic_pkg;

  localparam int DEF_DATA_SIZE       = 32;
  localparam int DEF_NUM_COLS        = 4;
  localparam int DEF_MULTIPLY_CYCLES = 3;
  localparam int DEF_FIFO_DEPTH      = 16;

  // One assembled row at the default geometry, column 0 in the low element.
  typedef logic [DEF_NUM_COLS-1:0][DEF_DATA_SIZE-1:0] row_t;

  // Column c lags column 0 by c cycles, so delaying it by n-1-c lines
  // every column up with the last (undelayed) column.
  function automatic int skew_delay(input int c, input int n);
    return n - 1 - c;
  endfunction

endpackage

// File: rtl/systolic_result_drain_if.sv
// Bundle of the array-side inputs, the row stream and the status outputs
// of the result drain.
//
// Row stream handshake: row_valid/row_data are driven by the drain, row_ready
// by the consumer. A row transfers on a rising clk edge where both row_valid
// and row_ready are 1. Once row_valid is 1 it stays 1 and row_data stays
// stable until that transfer; row_valid never depends combinationally on
// row_ready. array_enable is advisory back-pressure for the array and feeder.
interface systolic_result_drain_if
  import systolic_pkg::*;
#(
  parameter int DATA_SIZE  = DEF_DATA_SIZE,
  parameter int NUM_COLS   = DEF_NUM_COLS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_COLS-1:0]           col_valid;
  logic [NUM_COLS*DATA_SIZE-1:0] col_data;
  logic                          array_enable;
  logic                          row_valid;
  logic                          row_ready;
  logic [NUM_COLS*DATA_SIZE-1:0] row_data;
  logic [CNT_W-1:0]              row_count;
  logic                          skew_err;
  logic                          overflow_err;

  // Environment side: feeds the columns and consumes rows.
  modport master (
    output col_valid, col_data, row_ready,
    input  array_enable, row_valid, row_data, row_count, skew_err, overflow_err
  );

  // Drain side.
  modport slave (
    input  col_valid, col_data, row_ready,
    output array_enable, row_valid, row_data, row_count, skew_err, overflow_err
  );

endinterface

// File: rtl/VX_shift_register.sv
// Fixed-depth shift register. Only the top RESETW bits (the valid flag
// in this design) are cleared by reset; the payload bits just shift.
module VX_shift_register #(
  parameter int DATAW  = 33,
  parameter int RESETW = 1,
  parameter int DEPTH  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out
);

  function automatic logic [DATAW-1:0] reset_mask();
    logic [DATAW-1:0] m;
    for (int i = 0; i < DATAW; i++) m[i] = (i >= DATAW - RESETW);
    return m;
  endfunction

  localparam logic [DATAW-1:0] RST_MASK = reset_mask();

  logic [DATAW-1:0] stage_q [DEPTH];
  logic [DATAW-1:0] stage_d [DEPTH];

  // Next stage contents: shift by one when enabled, otherwise hold.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) stage_d[i] = stage_q[i];
    if (enable) begin
      stage_d[0] = data_in;
      for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers; reset drops the flagged bits so no stale valid survives.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset) stage_q[i] <= stage_d[i] & ~RST_MASK;
      else       stage_q[i] <= stage_d[i];
    end
  end

  assign data_out = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_drain_fifo.sv
// Synchronous row FIFO with occupancy count. Head is read combinationally
// from storage; a write becomes visible the cycle after it is accepted.
// Push and pop together are honoured when full (the pop frees the slot).
module systolic_drain_fifo
  import systolic_pkg::*;
#(
  parameter int WIDTH = DEF_NUM_COLS * DEF_DATA_SIZE,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointer/count update; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Row storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/systolic_result_drain.sv
// Removes the per-column skew of results leaving the bottom of the systolic
// array, assembles complete rows and queues them for a valid/ready consumer.
// array_enable throttles the array early enough that results already in
// flight (SKID of them) always fit in the FIFO.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int DATA_SIZE       = DEF_DATA_SIZE,
  parameter int NUM_COLS        = DEF_NUM_COLS,
  parameter int MULTIPLY_CYCLES = DEF_MULTIPLY_CYCLES,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
  input logic                    clk,
  input logic                    reset,
  systolic_result_drain_if.slave bus
);

  localparam int SKID  = NUM_COLS + MULTIPLY_CYCLES;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ROW_W = NUM_COLS * DATA_SIZE;

  logic [NUM_COLS-1:0]  dv;
  logic [DATA_SIZE-1:0] dd [NUM_COLS];
  logic [ROW_W-1:0]     row_in;

  logic [ROW_W-1:0]     fifo_rdata;
  logic [CNT_W-1:0]     count;
  logic                 fifo_full, fifo_empty;

  logic                 push_req, pop, fifo_wr, ovf_event, disagree;
  logic [CNT_W-1:0]     count_next;

  logic array_enable_q, array_enable_d;
  logic skew_err_q, skew_err_d;
  logic overflow_err_q, overflow_err_d;

  // Free-running per-column delay lines; the last column needs none.
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_deskew
    localparam int DLY = skew_delay(c, NUM_COLS);
    if (DLY == 0) begin : g_wire
      assign dv[c] = bus.col_valid[c];
      assign dd[c] = bus.col_data[c*DATA_SIZE +: DATA_SIZE];
    end else begin : g_sr
      logic [DATA_SIZE:0] sr_out;
      VX_shift_register #(
        .DATAW (DATA_SIZE + 1),
        .RESETW(1),
        .DEPTH (DLY)
      ) u_sr (
        .clk     (clk),
        .reset   (reset),
        .enable  (1'b1),
        .data_in ({bus.col_valid[c], bus.col_data[c*DATA_SIZE +: DATA_SIZE]}),
        .data_out(sr_out)
      );
      assign dv[c] = sr_out[DATA_SIZE];
      assign dd[c] = sr_out[DATA_SIZE-1:0];
    end
  end

  // Assemble the aligned row, decide push/pop, and compute flag/enable updates.
  always_comb begin
    row_in = '0;
    for (int c = 0; c < NUM_COLS; c++) row_in[c*DATA_SIZE +: DATA_SIZE] = dd[c];
    disagree       = (dv != {NUM_COLS{dv[0]}});
    push_req       = &dv;
    pop            = !fifo_empty && bus.row_ready;
    fifo_wr        = push_req && (!fifo_full || pop);
    ovf_event      = push_req && fifo_full && !pop;
    count_next     = count + CNT_W'(fifo_wr) - CNT_W'(pop);
    array_enable_d = (count_next <= CNT_W'(FIFO_DEPTH - SKID));
    skew_err_d     = skew_err_q | disagree;
    overflow_err_d = overflow_err_q | ovf_event;
  end

  // Registered enable and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      array_enable_q <= 1'b1;
      skew_err_q     <= 1'b0;
      overflow_err_q <= 1'b0;
    end else begin
      array_enable_q <= array_enable_d;
      skew_err_q     <= skew_err_d;
      overflow_err_q <= overflow_err_d;
    end
  end

  systolic_drain_fifo #(
    .WIDTH(ROW_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_wr),
    .pop  (pop),
    .wdata(row_in),
    .rdata(fifo_rdata),
    .count(count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign bus.array_enable = array_enable_q;
  assign bus.row_valid    = !fifo_empty;
  assign bus.row_data     = fifo_rdata;
  assign bus.row_count    = count;
  assign bus.skew_err     = skew_err_q;
  assign bus.overflow_err = overflow_err_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: skewed rows are driven column by
// column, expected rows go into exp_q, and a negedge scoreboard compares every
// accepted row against the queue head.
module tb_systolic_result_drain;
  import systolic_pkg::*;

  localparam int DS   = 32;
  localparam int NC   = 4;
  localparam int MC   = 3;
  localparam int FD   = 16;
  localparam int SKID = NC + MC;
  localparam int RW   = NC * DS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  systolic_result_drain_if #(.DATA_SIZE(DS), .NUM_COLS(NC), .FIFO_DEPTH(FD)) bus ();

  systolic_result_drain #(
    .DATA_SIZE(DS), .NUM_COLS(NC), .MULTIPLY_CYCLES(MC), .FIFO_DEPTH(FD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DS-1:0] elem(input int tag, input int r, input int c);
    return DS'((tag << 16) | (r << 8) | (c + 1));
  endfunction

  function automatic logic [RW-1:0] row_of(input int tag, input int r);
    logic [RW-1:0] v;
    v = '0;
    for (int c = 0; c < NC; c++) v[c*DS +: DS] = elem(tag, r, c);
    return v;
  endfunction

  // Scoreboard: every accepted row must be the next expected one.
  always @(negedge clk) begin
    if (!reset && bus.row_valid && bus.row_ready) begin
      check_val("pop_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check_val("row_data", bus.row_data, exp_q.pop_front());
    end
  end

  // ---------------- drivers ----------------
  // One cycle of a skewed stream of n rows: column c carries row k-c.
  task automatic drive_step(input int k, input int n, input int tag,
                            input int drop_row, input int drop_col);
    logic [NC-1:0] v;
    logic [RW-1:0] d;
    v = '0;
    d = '0;
    for (int c = 0; c < NC; c++) begin
      int r;
      r = k - c;
      if (r >= 0 && r < n) begin
        v[c] = !(r == drop_row && c == drop_col);
        d[c*DS +: DS] = elem(tag, r, c);
      end
    end
    bus.col_valid = v;
    bus.col_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.col_valid = '0;
    bus.col_data  = '0;
  endtask

  // Whole skewed stream; rows r < n_record (except drop_row) are expected.
  task automatic send_rows(input int n, input int tag, input int drop_row,
                           input int drop_col, input int n_record);
    for (int r = 0; r < n_record; r++)
      if (r != drop_row) exp_q.push_back(row_of(tag, r));
    for (int k = 0; k < n + NC - 1; k++) drive_step(k, n, tag, drop_row, drop_col);
    idle_inputs();
  endtask

  task automatic drain_all();
    int i;
    i = 0;
    bus.row_ready = 1'b1;
    while (exp_q.size() != 0 && i < 100) begin
      @(posedge clk);
      #1;
      i++;
    end
    check_val("drain_done", exp_q.size() == 0, 1);
    @(posedge clk);
    #1;
    check_val("drain_empty_count", bus.row_count, 0);
    check_val("drain_empty_valid", bus.row_valid, 0);
    bus.row_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_cnt;
    reset         = 1'b1;
    bus.row_ready = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: reset / idle state
    @(posedge clk);
    #1;
    check_val("rst_row_valid", bus.row_valid, 0);
    check_val("rst_array_enable", bus.array_enable, 1);
    check_val("rst_row_count", bus.row_count, 0);
    check_val("rst_skew_err", bus.skew_err, 0);
    check_val("rst_overflow_err", bus.overflow_err, 0);

    // 2: single skewed row {1,2,3,4}
    bus.row_ready = 1'b1;
    exp_q.push_back(row_of(0, 0));
    drive_step(0, 1, 0, -1, -1);
    drive_step(1, 1, 0, -1, -1);
    drive_step(2, 1, 0, -1, -1);
    check_val("t2_not_yet_valid", bus.row_valid, 0);
    drive_step(3, 1, 0, -1, -1);
    check_val("t2_row_valid", bus.row_valid, 1);
    check_val("t2_row_data", bus.row_data, 128'h00000004_00000003_00000002_00000001);
    idle_inputs();
    @(posedge clk);
    #1;
    check_val("t2_valid_one_cycle", bus.row_valid, 0);
    bus.row_ready = 1'b0;

    // 3: 13 back-to-back rows with no consumer; enable follows occupancy
    for (int r = 0; r < 13; r++) exp_q.push_back(row_of(3, r));
    for (int k = 0; k < 13 + NC - 1; k++) begin
      drive_step(k, 13, 3, -1, -1);
      exp_cnt = (k - 2 < 0) ? 0 : ((k - 2 > 13) ? 13 : k - 2);
      check_val("t3_count", bus.row_count, exp_cnt);
      check_val("t3_array_enable", bus.array_enable, (exp_cnt <= FD - SKID) ? 1 : 0);
    end
    idle_inputs();
    drain_all();
    check_val("t3_overflow_err", bus.overflow_err, 0);
    check_val("t3_enable_back", bus.array_enable, 1);

    // 4: fill to 16, then one more push overflows
    send_rows(16, 4, -1, -1, 16);
    check_val("t4_full_count", bus.row_count, 16);
    check_val("t4_no_ovf_yet", bus.overflow_err, 0);
    send_rows(1, 14, -1, -1, 0);
    check_val("t4_overflow_err", bus.overflow_err, 1);
    check_val("t4_count_held", bus.row_count, 16);
    check_val("t4_head", bus.row_data, row_of(4, 0));
    check_val("t4_array_enable", bus.array_enable, 0);
    check_val("t4_skew_clear", bus.skew_err, 0);
    drain_all();

    // 5: column 2 valid missing for row 1
    bus.row_ready = 1'b1;
    send_rows(3, 5, 1, 2, 3);
    drain_all();
    check_val("t5_skew_err", bus.skew_err, 1);
    check_val("t5_overflow_sticky", bus.overflow_err, 1);

    // 6: reset with 5 rows queued and 2 in flight
    send_rows(5, 6, -1, -1, 5);
    check_val("t6_queued", bus.row_count, 5);
    drive_step(0, 2, 7, -1, -1);
    drive_step(1, 2, 7, -1, -1);
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    check_val("t6_count", bus.row_count, 0);
    check_val("t6_row_valid", bus.row_valid, 0);
    check_val("t6_skew_err", bus.skew_err, 0);
    check_val("t6_overflow_err", bus.overflow_err, 0);
    check_val("t6_array_enable", bus.array_enable, 1);
    bus.row_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check_val("t6_no_stale_row", bus.row_valid, 0);
    end
    bus.row_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
